// File: rtl/tone_sequencer.sv
// Two-channel tone half-period controller: manual switch value or a
// one-shot 5-step melody timed by a tick prescaler, final step held.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   switch     board switches; 0 selects melody, nonzero is manual value
//   freq1      channel 1 half-period (clock cycles)
//   freq2      channel 2 half-period (clock cycles)
//   seq_active high while melody steps 0..3 play
//   step_idx   current melody step (0..4); 0 in manual mode
module tone_sequencer #(
    parameter int TICK_DIV = 1,
    parameter int FW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    switch,
    output logic [FW-1:0] freq1,
    output logic [FW-1:0] freq2,
    output logic          seq_active,
    output logic [2:0]    step_idx
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0] F_BASE = FW'(20);

    typedef enum logic [1:0] {MANUAL, PLAY, HOLD} state_t;

    state_t        state, state_n;
    logic [3:0]    sw_q;
    logic [FW-1:0] freq1_n, freq2_n;
    logic          seq_active_n;
    logic [2:0]    step_idx_n;
    logic [2:0]    step_inc;
    logic [7:0]    dur_cnt, dur_cnt_n;
    logic [PW-1:0] presc, presc_n;
    logic          tick;

    function automatic logic [FW-1:0] step_freq1(input logic [2:0] s);
        logic [FW-1:0] f;
        case (s)
            3'd0:    f = FW'(20);
            3'd1:    f = FW'(5);
            3'd2:    f = FW'(1);
            3'd3:    f = FW'(24);
            default: f = FW'(20);
        endcase
        return f;
    endfunction

    // Last dur_cnt value of a step (duration in ticks minus one).
    function automatic logic [7:0] step_last(input logic [2:0] s);
        logic [7:0] d;
        case (s)
            3'd0:    d = 8'd199;
            3'd1:    d = 8'd59;
            3'd2:    d = 8'd39;
            3'd3:    d = 8'd19;
            default: d = 8'd0;
        endcase
        return d;
    endfunction

    // Input register runs through reset so the switch is known on release.
    always_ff @(posedge clk) begin
        sw_q <= switch;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= MANUAL;
            freq1      <= F_BASE;
            freq2      <= F_BASE;
            seq_active <= 1'b0;
            step_idx   <= 3'd0;
            dur_cnt    <= 8'd0;
            presc      <= '0;
        end else begin
            state      <= state_n;
            freq1      <= freq1_n;
            freq2      <= freq2_n;
            seq_active <= seq_active_n;
            step_idx   <= step_idx_n;
            dur_cnt    <= dur_cnt_n;
            presc      <= presc_n;
        end
    end

    always_comb begin
        state_n      = state;
        freq1_n      = freq1;
        freq2_n      = freq2;
        seq_active_n = seq_active;
        step_idx_n   = step_idx;
        dur_cnt_n    = dur_cnt;
        presc_n      = '0;
        tick         = (presc == PRESC_LAST);
        step_inc     = step_idx + 3'd1;

        unique case (state)
            MANUAL: begin
                if (sw_q != 4'd0) begin
                    freq1_n      = FW'(sw_q);
                    freq2_n      = FW'(sw_q);
                    seq_active_n = 1'b0;
                    step_idx_n   = 3'd0;
                end else begin
                    state_n      = PLAY;
                    freq1_n      = step_freq1(3'd0);
                    freq2_n      = F_BASE;
                    seq_active_n = 1'b1;
                    step_idx_n   = 3'd0;
                    dur_cnt_n    = 8'd0;
                end
            end
            PLAY: begin
                if (sw_q != 4'd0) begin
                    state_n      = MANUAL;
                    freq1_n      = FW'(sw_q);
                    freq2_n      = FW'(sw_q);
                    seq_active_n = 1'b0;
                    step_idx_n   = 3'd0;
                    dur_cnt_n    = 8'd0;
                end else begin
                    presc_n = tick ? '0 : presc + PW'(1);
                    if (tick) begin
                        if (dur_cnt == step_last(step_idx)) begin
                            dur_cnt_n = 8'd0;
                            freq1_n   = step_freq1(step_inc);
                            freq2_n   = F_BASE;
                            step_idx_n = step_inc;
                            if (step_idx == 3'd3) begin
                                state_n      = HOLD;
                                seq_active_n = 1'b0;
                            end
                        end else begin
                            dur_cnt_n = dur_cnt + 8'd1;
                        end
                    end
                end
            end
            HOLD: begin
                if (sw_q != 4'd0) begin
                    state_n      = MANUAL;
                    freq1_n      = FW'(sw_q);
                    freq2_n      = FW'(sw_q);
                    seq_active_n = 1'b0;
                    step_idx_n   = 3'd0;
                    dur_cnt_n    = 8'd0;
                end
            end
            default: begin
                state_n = MANUAL;
            end
        endcase
    end

endmodule
